// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: bus widths, field offsets and packed views of the WB input and forward buses
`define WB_FWD_VALID        85
`define WB_FWD_CSR_WEN      84
`define WB_FWD_CSR_ADDR_LSB 70
`define WB_FWD_CSR_DATA_LSB 38
`define WB_FWD_GR_WE        37
`define WB_FWD_DEST_LSB     32
`define WB_FWD_RESULT_LSB   0
package wb_stage_pkg;
  localparam int ES_TO_WS_BUS_WD = 117;
  localparam int FORWAED_BUS_WD  = 86;
  typedef struct packed {
    logic        csr_wen;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ws_t;
  typedef struct packed {
    logic        valid;
    logic        csr_wen;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } fwd_t;
endpackage

// File: rtl/wb_retire_cnt.sv
// wb_retire_cnt: wrapping count of committed instructions
module wb_retire_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = cnt_q + CNT_W'(inc_i);
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback commit, RF/CSR write ports, forwarding buses and retire counter.
// Optional difftest trace ports under WB_TRACE_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 es_to_ws_valid,
  input  logic [ES_TO_WS_BUS_WD-1:0] es_to_ws_bus,
  output logic                       ws_ready,
  output logic [FORWAED_BUS_WD-1:0]  forward_data1,
  output logic [FORWAED_BUS_WD-1:0]  forward_data2,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic                       csr_we,
  output logic [13:0]                csr_waddr,
  output logic [31:0]                csr_wdata,
  output logic [CNT_W-1:0]           retire_cnt
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_we,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
`endif
);
  es_to_ws_t bus;
  fwd_t      fwd_d, commit_q;
  logic      commit;
  assign bus = es_to_ws_bus;
  always_comb begin
    commit        = es_to_ws_valid[0] & es_to_ws_valid[1];
    ws_ready      = ~(es_to_ws_valid[0] & ~es_to_ws_valid[1]);
    fwd_d         = '{valid: commit, csr_wen: bus.csr_wen, csr_addr: bus.csr_addr,
                      csr_wdata: bus.csr_wdata, gr_we: bus.gr_we, dest: bus.dest,
                      result: bus.result};
    forward_data2 = fwd_d;
    forward_data1 = commit_q;
    rf_we         = commit_q.valid & commit_q.gr_we & (commit_q.dest != 5'd0);
    rf_waddr      = commit_q.dest;
    rf_wdata      = commit_q.result;
    csr_we        = commit_q.valid & commit_q.csr_wen;
    csr_waddr     = commit_q.csr_addr;
    csr_wdata     = commit_q.csr_wdata;
  end
  // Stalls and bubbles load an all-zero entry so nothing stale reaches the write ports.
  always_ff @(posedge clk) begin
    if (reset) commit_q <= '0;
    else commit_q <= commit ? fwd_d : '0;
  end
`ifdef WB_TRACE_EN
  logic [31:0] pc_q;
  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else pc_q <= commit ? bus.pc : '0;
  end
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = commit_q.dest;
  assign debug_wb_rf_wdata = commit_q.result;
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc;
`endif
  wb_retire_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk  (clk),
    .reset(reset),
    .inc_i(commit),
    .cnt_o(retire_cnt)
  );
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed stimulus with a per-cycle reference model of the writeback stage.
// Drives a default-width instance and a CNT_W=4 instance in parallel for the wrap case.
module tb_wb_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   v;
  logic [116:0] bus;
  logic         ws_ready, ws_ready4;
  logic [85:0]  fd1, fd2, fd1_4, fd2_4;
  logic         rf_we, rf_we4, csr_we, csr_we4;
  logic [4:0]   rf_waddr, rf_waddr4;
  logic [31:0]  rf_wdata, rf_wdata4, csr_wdata, csr_wdata4;
  logic [13:0]  csr_waddr, csr_waddr4;
  logic [63:0]  retire_cnt;
  logic [3:0]   cnt4;
`ifdef WB_TRACE_EN
  logic [31:0]  dbg_pc, dbg_pc4, dbg_wdata, dbg_wdata4;
  logic [3:0]   dbg_we, dbg_we4;
  logic [4:0]   dbg_wnum, dbg_wnum4;
`endif
  logic         b_csr_wen = 1'b0, b_gr_we = 1'b0;
  logic [13:0]  b_csr_addr = '0;
  logic [31:0]  b_csr_wdata = '0, b_result = '0, b_pc = 32'h1c000000;
  logic [4:0]   b_dest = '0;
  assign bus = {b_csr_wen, b_csr_addr, b_csr_wdata, b_gr_we, b_dest, b_result, b_pc};
  wb_stage dut (
    .clk(clk), .reset(reset), .es_to_ws_valid(v), .es_to_ws_bus(bus), .ws_ready(ws_ready),
    .forward_data1(fd1), .forward_data2(fd2), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .retire_cnt(retire_cnt)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(dbg_pc), .debug_wb_rf_we(dbg_we), .debug_wb_rf_wnum(dbg_wnum),
    .debug_wb_rf_wdata(dbg_wdata)
`endif
  );
  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .es_to_ws_valid(v), .es_to_ws_bus(bus), .ws_ready(ws_ready4),
    .forward_data1(fd1_4), .forward_data2(fd2_4), .rf_we(rf_we4), .rf_waddr(rf_waddr4),
    .rf_wdata(rf_wdata4), .csr_we(csr_we4), .csr_waddr(csr_waddr4), .csr_wdata(csr_wdata4),
    .retire_cnt(cnt4)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(dbg_pc4), .debug_wb_rf_we(dbg_we4), .debug_wb_rf_wnum(dbg_wnum4),
    .debug_wb_rf_wdata(dbg_wdata4)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: the last cycle's committed instruction, and a commit tally.
  bit          model_ok = 0;
  bit          p_v;
  logic        p_csr_wen, p_gr_we;
  logic [13:0] p_csr_addr;
  logic [31:0] p_csr_wdata, p_result, p_pc;
  logic [4:0]  p_dest;
  logic [63:0] exp_cnt;
  function automatic logic [85:0] cur_fd();
    return {v[0] & v[1], b_csr_wen, b_csr_addr, b_csr_wdata, b_gr_we, b_dest, b_result};
  endfunction
  always @(posedge clk) begin
    if (reset) begin
      p_v = 0; exp_cnt = 0; model_ok = 1;
    end else begin
      p_v = v[0] && v[1];
      {p_csr_wen, p_csr_addr, p_csr_wdata, p_gr_we, p_dest, p_result, p_pc} =
        {b_csr_wen, b_csr_addr, b_csr_wdata, b_gr_we, b_dest, b_result, b_pc};
      if (p_v) exp_cnt = exp_cnt + 1;
    end
  end
  always @(negedge clk) begin
    if (model_ok) begin
      chk("ws_ready", ws_ready, !(v[0] && !v[1]));
      chk("ws_ready4", ws_ready4, !(v[0] && !v[1]));
      chk("fwd2", fd2, cur_fd());
      chk("fwd1_valid", fd1[85], p_v);
      if (p_v) chk("fwd1", fd1, {1'b1, p_csr_wen, p_csr_addr, p_csr_wdata, p_gr_we, p_dest, p_result});
      chk("rf_we", rf_we, p_v && p_gr_we && p_dest != 0);
      if (p_v && p_gr_we && p_dest != 0) begin
        chk("rf_waddr", rf_waddr, p_dest);
        chk("rf_wdata", rf_wdata, p_result);
      end
      chk("csr_we", csr_we, p_v && p_csr_wen);
      if (p_v && p_csr_wen) begin
        chk("csr_waddr", csr_waddr, p_csr_addr);
        chk("csr_wdata", csr_wdata, p_csr_wdata);
      end
      chk("retire_cnt", retire_cnt, exp_cnt);
      chk("retire_cnt4", cnt4, exp_cnt[3:0]);
`ifdef WB_TRACE_EN
      chk("dbg_we", dbg_we, {4{p_v && p_gr_we && p_dest != 0}});
      if (p_v) begin
        chk("dbg_pc", dbg_pc, p_pc);
        chk("dbg_wnum", dbg_wnum, p_dest);
        chk("dbg_wdata", dbg_wdata, p_result);
      end
`endif
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ins(input logic cw, input logic [13:0] ca, input logic [31:0] cd,
                     input logic g, input logic [4:0] d, input logic [31:0] r);
    {b_csr_wen, b_csr_addr, b_csr_wdata, b_gr_we, b_dest, b_result} = {cw, ca, cd, g, d, r};
    b_pc = b_pc + 32'd4;
  endtask
  initial begin
    reset = 1'b1;
    v = 2'b10;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_ws_ready", ws_ready, 1);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_fwd1", fd1, 0);
    chk("reset_cnt", retire_cnt, 0);
    reset = 1'b0;
    v = 2'b00;
    tick();
    // single commit
    ins(0, 0, 0, 1, 5'd5, 32'h1234);
    v = 2'b11;
    @(negedge clk);
    chk("single_fwd2_valid", fd2[85], 1);
    chk("single_fwd2_dest", fd2[36:32], 5);
    tick();
    v = 2'b00;
    @(negedge clk);
    chk("single_rf_we", rf_we, 1);
    chk("single_rf_waddr", rf_waddr, 5);
    chk("single_rf_wdata", rf_wdata, 32'h1234);
    chk("single_cnt", retire_cnt, 1);
    tick();
    // stall three cycles, then complete
    ins(0, 0, 0, 1, 5'd7, 32'hBEEF);
    v = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ws_ready", ws_ready, 0);
      chk("stall_rf_we", rf_we, 0);
      tick();
    end
    v = 2'b11;
    tick();
    v = 2'b00;
    @(negedge clk);
    chk("stall_rf_we_after", rf_we, 1);
    chk("stall_rf_waddr", rf_waddr, 7);
    chk("stall_cnt", retire_cnt, 2);
    tick();
    @(negedge clk);
    chk("stall_once", rf_we, 0);
    // dest 0 is committed but never written
    ins(0, 0, 0, 1, 5'd0, 32'h55);
    v = 2'b11;
    tick();
    v = 2'b00;
    @(negedge clk);
    chk("dest0_rf_we", rf_we, 0);
    chk("dest0_cnt", retire_cnt, 3);
    tick();
    // CSR write
    ins(1, 14'h0006, 32'hA5A5A5A5, 0, 5'd0, 32'h0);
    v = 2'b11;
    @(negedge clk);
    chk("csr_fwd2_wen", fd2[84], 1);
    tick();
    v = 2'b00;
    @(negedge clk);
    chk("csr_we_lit", csr_we, 1);
    chk("csr_waddr_lit", csr_waddr, 14'h0006);
    chk("csr_wdata_lit", csr_wdata, 32'hA5A5A5A5);
    tick();
    // back-to-back commits to one dest
    ins(0, 0, 0, 1, 5'd9, 32'h1);
    v = 2'b11;
    tick();
    ins(0, 0, 0, 1, 5'd9, 32'h2);
    @(negedge clk);
    chk("b2b_fwd1_dest", fd1[36:32], 9);
    chk("b2b_fwd1_result", fd1[31:0], 1);
    chk("b2b_fwd2_result", fd2[31:0], 2);
    tick();
    v = 2'b00;
    tick();
    // reset in the middle of a stall
    ins(1, 14'h0010, 32'h77, 1, 5'd3, 32'h33);
    v = 2'b01;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall_cnt", retire_cnt, 0);
    chk("rst_stall_rf_we", rf_we, 0);
    chk("rst_stall_csr_we", csr_we, 0);
    chk("rst_stall_fwd1", fd1, 0);
    chk("rst_stall_rf_waddr", rf_waddr, 0);
    tick();
    v = 2'b00;
    tick();
    @(negedge clk);
    chk("rst_stall_no_write", rf_we, 0);
    chk("rst_stall_cnt2", retire_cnt, 0);
    tick();
    // 17 consecutive commits wrap the 4-bit counter to 1
    v = 2'b11;
    for (int i = 0; i < 17; i++) begin
      ins(i[0], 14'(i), 32'(i * 3), 1, 5'(i + 1), 32'(i * 7 + 1));
      tick();
    end
    v = 2'b00;
    @(negedge clk);
    chk("wrap_cnt4", cnt4, 1);
    chk("wrap_cnt64", retire_cnt, 17);
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
